// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- sequencer and HI/LO owner for the E-stage multiply/divide unit.
//
// Accepts one mult/multu/div/divu per start pulse. The operation is modelled
// with a fixed-latency countdown, and the result is written into HI/LO on the
// final busy edge. mthi/mtlo write HI or LO one edge after they are presented.
// While an operation is in flight, any MDU-class instruction in D is stalled.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (default 5)
//   DIV_CYCLES   busy cycles for div/divu   (default 10)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   start      in   E-stage instruction is mult/multu/div/divu
//   mduOp      in   [3:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                   5 mthi, 6 mtlo, others none
//   d1, d2     in   [31:0] rs / rt operands (forwarded)
//   req        in   exception/interrupt taken; the E-stage instruction is flushed
//   d_mdu_use  in   D-stage instruction is md, mt or mf
//   busy       out  operation in flight (registered, mirrors state RUN)
//   stall_mdu  out  D-stage stall request (combinational)
//   hi, lo     out  [31:0] HI / LO registers
//
// Optional feature macro: MDU_REQ_FLUSH_EN
//   When defined, req=1 blocks acceptance of start and of mthi/mtlo in that
//   cycle. An operation that is already running always completes.
//   When undefined, req is ignored.
//
// Handshake: start is a single-cycle request with no ready signal. It is
// accepted only in IDLE. The D-stage stall guarantees that no new MDU
// instruction reaches E while busy=1; a request presented while busy=1 is
// dropped. The FSM state is externally visible as busy (busy == RUN).
// ---------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mduOp,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic        req,
  input  logic        d_mdu_use,
  output logic        busy,
  output logic        stall_mdu,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               accept_en;
  logic               is_md_op;
  logic               start_ok;
  logic               mt_ok;

  // Arithmetic on the latched operands. This logic is only consumed on the
  // final busy edge.
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

`ifdef MDU_REQ_FLUSH_EN
  assign accept_en = ~req;
`else
  logic unused_req;
  assign unused_req = req;
  assign accept_en  = 1'b1;
`endif

  always_comb begin
    // Sign-extend to 64 bits so the product keeps its full signed width.
    prod_s = 64'($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // SV signed '/' truncates toward zero and '%' takes the sign of the
    // dividend, which matches the architectural div result.
    quot_s = 32'($signed(a_q) / $signed(b_q));
    rem_s  = 32'($signed(a_q) % $signed(b_q));
    quot_u = a_q / b_q;
    rem_u  = a_q % b_q;
  end

  always_comb begin
    is_md_op = (mduOp == OP_MULT) || (mduOp == OP_MULTU) ||
               (mduOp == OP_DIV)  || (mduOp == OP_DIVU);
    start_ok = start & is_md_op & accept_en;
    mt_ok    = ~start & accept_en & ((mduOp == OP_MTHI) || (mduOp == OP_MTLO));

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          op_d    = mduOp;
          a_d     = d1;
          b_d     = d2;
          cnt_d   = ((mduOp == OP_MULT) || (mduOp == OP_MULTU)) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d = RUN;
        end else if (mt_ok) begin
          if (mduOp == OP_MTHI) hi_d = d1;
          else                  lo_d = d1;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              // A zero divisor still takes the full latency but leaves HI/LO untouched.
              if (b_q != 32'd0) begin
                lo_d = quot_s;
                hi_d = rem_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == RUN);
  // The raw start bit is used so that the instruction behind an MDU op in E
  // stalls in the same cycle the op issues.
  assign stall_mdu = d_mdu_use & (busy | start);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl.
// A table of mult/div vectors is run back to back. Expected HI/LO values are
// queued when an operation starts and compared when busy falls. Hand-written
// sequences cover mthi/mtlo, division by zero, start during RUN, invalid ops,
// reset in the middle of a div, and req handling (MDU_REQ_FLUSH_EN).
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int NVEC   = 12;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mduOp;
  logic [31:0] d1, d2;
  logic        req;
  logic        d_mdu_use;
  logic        busy;
  logic        stall_mdu;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[NVEC];

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mduOp     (mduOp),
    .d1        (d1),
    .d2        (d2),
    .req       (req),
    .d_mdu_use (d_mdu_use),
    .busy      (busy),
    .stall_mdu (stall_mdu),
    .hi        (hi),
    .lo        (lo)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model. The result is {hi, lo}; prev is returned on a zero divisor.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    logic [63:0] ax, bx;
    logic [31:0] ma, mb, q, r;
    case (op)
      4'd1: begin
        ax = {{32{a[31]}}, a};
        bx = {{32{b[31]}}, b};
        return ax * bx;
      end
      4'd2: return {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) return prev;
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] != b[31]) q = ~q + 32'd1;
        if (a[31])          r = ~r + 32'd1;
        return {r, q};
      end
      4'd4: begin
        if (b == 32'd0) return prev;
        return {a % b, a / b};
      end
      default: return prev;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1. Issues one op, counts the busy cycles and compares
  // the result when busy falls. When intrude=1, a second start is presented
  // in the middle of RUN and must have no effect.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int n, input bit intrude);
    int          cyc;
    bit          stall_ok;
    bit          stable_ok;
    logic [63:0] hold;
    logic [63:0] exp;
    start     = 1'b1;
    mduOp     = op;
    d1        = a;
    d2        = b;
    d_mdu_use = 1'b1;
    exp_q.push_back({ehi, elo});
    #1;
    check({name, " stall_start"}, {63'd0, stall_mdu}, 64'd1);
    hold = {hi, lo};
    tick();
    start = 1'b0;
    mduOp = 4'd0;
    d1    = $urandom;
    d2    = $urandom;
    cyc       = 0;
    stall_ok  = 1'b1;
    stable_ok = 1'b1;
    while (busy && cyc < 100) begin
      cyc++;
      if (!stall_mdu) stall_ok = 1'b0;
      if ({hi, lo} !== hold) stable_ok = 1'b0;
      if (intrude && cyc == 2) begin
        start = 1'b1;
        mduOp = 4'd3;
        d1    = 32'd100;
        d2    = 32'd7;
      end else begin
        start = 1'b0;
        mduOp = 4'd0;
      end
      tick();
    end
    start = 1'b0;
    mduOp = 4'd0;
    check({name, " busy_cycles"}, 64'(cyc), 64'(n));
    check({name, " stall_busy"}, {63'd0, stall_ok}, 64'd1);
    check({name, " hilo_stable"}, {63'd0, stable_ok}, 64'd1);
    check({name, " stall_after"}, {63'd0, stall_mdu}, 64'd0);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: queue empty", name);
    end else begin
      exp = exp_q.pop_front();
      check({name, " hilo"}, {hi, lo}, exp);
    end
  endtask

  task automatic mt_write(input logic [3:0] op, input logic [31:0] v);
    start = 1'b0;
    mduOp = op;
    d1    = v;
    tick();
    mduOp = 4'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] prev;
    int n;
    start = 1'b0; mduOp = 4'd0; d1 = '0; d2 = '0; req = 1'b0; d_mdu_use = 1'b0;
    reset = 1'b1;

    vecs[0] = '{4'd1, 32'hFFFFFFFF, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,          32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{4'd4, 32'd7,        32'd2,          32'd1,        32'd3};
    vecs[4] = '{4'd3, 32'd7,        32'hFFFFFFFE,   32'd1,        32'hFFFFFFFD};
    vecs[5] = '{4'd1, 32'h00010000, 32'h00010000,   32'd1,        32'd0};
    for (int i = 6; i < NVEC; i++) begin
      vecs[i].op = 4'($urandom_range(1, 4));
      vecs[i].d1 = $urandom;
      vecs[i].d2 = $urandom_range(1, 32'h7FFFFFFF) | (32'($urandom_range(0, 1)) << 31);
      {vecs[i].hi, vecs[i].lo} = model(vecs[i].op, vecs[i].d1, vecs[i].d2, 64'd0);
    end

    repeat (2) tick();
    reset = 1'b0;
    d_mdu_use = 1'b1;
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset stall", {63'd0, stall_mdu}, 64'd0);

    // Back-to-back table vectors.
    for (int i = 0; i < NVEC; i++) begin
      n = (vecs[i].op <= 4'd2) ? MULT_N : DIV_N;
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].d1, vecs[i].d2,
             vecs[i].hi, vecs[i].lo, n, 1'b0);
    end

    // mthi / mtlo take effect one edge later.
    start = 1'b0; mduOp = 4'd5; d1 = 32'hA5A5A5A5;
    prev = {hi, lo};
    #1;
    check("mthi before edge", {hi, lo}, prev);
    tick();
    mduOp = 4'd6; d1 = 32'h5A5A5A5A;
    check("mthi hi", {32'd0, hi}, {32'd0, 32'hA5A5A5A5});
    check("mthi busy", {63'd0, busy}, 64'd0);
    tick();
    mduOp = 4'd0;
    check("mtlo hilo", {hi, lo}, {32'hA5A5A5A5, 32'h5A5A5A5A});

    // divu by zero keeps the previous HI/LO after the full latency.
    mt_write(4'd5, 32'h1234);
    mt_write(4'd6, 32'h1234);
    prev = {hi, lo};
    run_op("divu0", 4'd4, 32'd7, 32'd0, prev[63:32], prev[31:0], DIV_N, 1'b0);
    check("divu0 model", model(4'd4, 32'd7, 32'd0, prev), {32'h1234, 32'h1234});

    // A start presented during RUN is ignored.
    run_op("intrude", 4'd2, 32'd3, 32'd4, 32'd0, 32'd12, MULT_N, 1'b1);
    tick();
    check("intrude idle", {63'd0, busy}, 64'd0);

    // A start with an invalid op is ignored.
    prev = {hi, lo};
    start = 1'b1; mduOp = 4'd7; d1 = 32'd9; d2 = 32'd9;
    tick();
    start = 1'b0; mduOp = 4'd0;
    check("badop busy", {63'd0, busy}, 64'd0);
    check("badop hilo", {hi, lo}, prev);

    // Reset in the third busy cycle of a div: the result is lost.
    start = 1'b1; mduOp = 4'd3; d1 = 32'd100; d2 = 32'd7;
    tick();
    start = 1'b0; mduOp = 4'd0;
    repeat (2) tick();
    check("pre-reset busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    repeat (DIV_N + 2) tick();
    check("midreset lost", {hi, lo}, 64'd0);

    // req together with start (and with mthi).
    mt_write(4'd5, 32'hCAFE0001);
    mt_write(4'd6, 32'hCAFE0002);
    prev = {hi, lo};
`ifdef MDU_REQ_FLUSH_EN
    req = 1'b1; start = 1'b1; mduOp = 4'd1; d1 = 32'd6; d2 = 32'd7;
    tick();
    req = 1'b0; start = 1'b0; mduOp = 4'd0;
    check("flush busy", {63'd0, busy}, 64'd0);
    repeat (MULT_N + 1) tick();
    check("flush hilo", {hi, lo}, prev);
    req = 1'b1; mduOp = 4'd5; d1 = 32'h11111111;
    tick();
    req = 1'b0; mduOp = 4'd0;
    check("flush mthi", {hi, lo}, prev);
`else
    req = 1'b1;
    run_op("noflush", 4'd1, 32'd6, 32'd7, 32'd0, 32'd42, MULT_N, 1'b0);
    req = 1'b0;
`endif

    // Stall depends on d_mdu_use.
    d_mdu_use = 1'b0;
    start = 1'b1; mduOp = 4'd1; d1 = 32'd2; d2 = 32'd2;
    #1;
    check("nouse stall", {63'd0, stall_mdu}, 64'd0);
    tick();
    start = 1'b0; mduOp = 4'd0;
    check("nouse stall busy", {63'd0, stall_mdu}, 64'd0);
    repeat (MULT_N) tick();
    check("nouse result", {hi, lo}, 64'd4);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: %0d entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
